// File: rtl/projection_histogram_engine.sv
`default_nettype none
// ============================================================================
// Module   : projection_histogram_engine
// Purpose  : Per-column / per-row set-pixel histograms with saturating bins,
//            peak tracking and a back-pressured readout stream.
// Revision : 1.0
// ============================================================================
module projection_histogram_engine #(
    parameter int X_BINS  = 240,
    parameter int Y_BINS  = 180,
    parameter int ADDR_W  = 8,
    parameter int COUNT_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [ADDR_W-1:0]  xAddress,
    input  logic [ADDR_W-1:0]  yAddress,
    input  logic               pixelData,
    input  logic               pixelValid,
    input  logic               startHistogram,
    input  logic               frameAccum,
    input  logic               stopHistogram,
    input  logic               clearHistogram,
    input  logic               readHistogram,
    input  logic               outReady,
    output logic [COUNT_W-1:0] xHistogramOut,
    output logic [COUNT_W-1:0] yHistogramOut,
    output logic [ADDR_W-1:0]  xIndex,
    output logic [ADDR_W-1:0]  yIndex,
    output logic               xValid,
    output logic               yValid,
    output logic [ADDR_W-1:0]  xPeakBin,
    output logic [ADDR_W-1:0]  yPeakBin,
    output logic [COUNT_W-1:0] xPeakCount,
    output logic [COUNT_W-1:0] yPeakCount,
    output logic               histogramClear,
    output logic               readDone,
    output logic               busy
);
    localparam int MAX_BINS = (X_BINS > Y_BINS) ? X_BINS : Y_BINS;
    localparam int IDX_W    = $clog2(MAX_BINS + 1);
    localparam logic [COUNT_W-1:0] CNT_MAX = {COUNT_W{1'b1}};
    localparam logic [COUNT_W-1:0] CNT_ONE = COUNT_W'(1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        ACCUM = 3'd2,
        DONE  = 3'd3,
        READ  = 3'd4
    } state_t;

    state_t state, state_next;

    logic [COUNT_W-1:0] x_bins [X_BINS];
    logic [COUNT_W-1:0] y_bins [Y_BINS];
    logic [IDX_W-1:0]   sweep_idx;
    logic [IDX_W-1:0]   rd_idx;
    logic               clear_then_accum;
    logic               rd_loaded;

    logic               idle_like, sweep_last, rd_step, rd_end, x_hit, y_hit;
    logic [COUNT_W-1:0] x_cur, y_cur, x_new, y_new, x_rd, y_rd;

    always_comb begin
        idle_like  = (state == IDLE) || (state == DONE);
        sweep_last = (int'(sweep_idx) == MAX_BINS - 1);
        // rd_idx points at the next word to present; MAX_BINS means all words were presented
        rd_step    = (state == READ) && (!rd_loaded || outReady);
        rd_end     = rd_step && (int'(rd_idx) == MAX_BINS);
        x_hit      = (state == ACCUM) && pixelValid && pixelData && (int'(xAddress) < X_BINS);
        y_hit      = (state == ACCUM) && pixelValid && pixelData && (int'(yAddress) < Y_BINS);
        x_cur = '0;
        x_rd  = '0;
        for (int i = 0; i < X_BINS; i++) begin
            if (int'(xAddress) == i) x_cur = x_bins[i];
            if (int'(rd_idx) == i)   x_rd  = x_bins[i];
        end
        y_cur = '0;
        y_rd  = '0;
        for (int i = 0; i < Y_BINS; i++) begin
            if (int'(yAddress) == i) y_cur = y_bins[i];
            if (int'(rd_idx) == i)   y_rd  = y_bins[i];
        end
        x_new = (x_cur == CNT_MAX) ? x_cur : x_cur + CNT_ONE;
        y_new = (y_cur == CNT_MAX) ? y_cur : y_cur + CNT_ONE;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE: begin
                if (clearHistogram)
                    state_next = CLEAR;
                else if (startHistogram)
                    state_next = frameAccum ? ACCUM : CLEAR;
                else if (readHistogram && (state == DONE))
                    state_next = READ;
            end
            CLEAR:   if (sweep_last) state_next = clear_then_accum ? ACCUM : IDLE;
            ACCUM:   if (stopHistogram) state_next = DONE;
            READ:    if (rd_end) state_next = DONE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    for (genvar i = 0; i < X_BINS; i++) begin : g_xbin
        always_ff @(posedge clk or negedge reset) begin
            if (!reset)
                x_bins[i] <= '0;
            else if ((state == CLEAR) && (sweep_idx == IDX_W'(i)))
                x_bins[i] <= '0;
            else if (x_hit && (xAddress == ADDR_W'(i)))
                x_bins[i] <= x_new;
        end
    end

    for (genvar i = 0; i < Y_BINS; i++) begin : g_ybin
        always_ff @(posedge clk or negedge reset) begin
            if (!reset)
                y_bins[i] <= '0;
            else if ((state == CLEAR) && (sweep_idx == IDX_W'(i)))
                y_bins[i] <= '0;
            else if (y_hit && (yAddress == ADDR_W'(i)))
                y_bins[i] <= y_new;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sweep_idx        <= '0;
            rd_idx           <= '0;
            clear_then_accum <= 1'b0;
            rd_loaded        <= 1'b0;
            xPeakBin         <= '0;
            yPeakBin         <= '0;
            xPeakCount       <= '0;
            yPeakCount       <= '0;
            xHistogramOut    <= '0;
            yHistogramOut    <= '0;
            xIndex           <= '0;
            yIndex           <= '0;
            xValid           <= 1'b0;
            yValid           <= 1'b0;
            histogramClear   <= 1'b0;
            readDone         <= 1'b0;
            busy             <= 1'b0;
        end else begin
            histogramClear <= 1'b0;
            readDone       <= 1'b0;
            busy           <= (state_next != IDLE) && (state_next != DONE);

            if (idle_like && (state_next == CLEAR)) begin
                sweep_idx        <= '0;
                clear_then_accum <= !clearHistogram;
                xPeakBin         <= '0;
                yPeakBin         <= '0;
                xPeakCount       <= '0;
                yPeakCount       <= '0;
            end

            if (state == CLEAR) begin
                sweep_idx <= sweep_idx + IDX_W'(1);
                if (sweep_last) histogramClear <= 1'b1;
            end

            // Strict greater-than keeps the bin that reached a tied value first
            if (x_hit && (x_new > xPeakCount)) begin
                xPeakBin   <= xAddress;
                xPeakCount <= x_new;
            end
            if (y_hit && (y_new > yPeakCount)) begin
                yPeakBin   <= yAddress;
                yPeakCount <= y_new;
            end

            if (idle_like && (state_next == READ)) begin
                rd_idx    <= '0;
                rd_loaded <= 1'b0;
            end

            if (rd_step) begin
                if (rd_end) begin
                    rd_loaded     <= 1'b0;
                    readDone      <= 1'b1;
                    xValid        <= 1'b0;
                    yValid        <= 1'b0;
                    xHistogramOut <= '0;
                    yHistogramOut <= '0;
                    xIndex        <= '0;
                    yIndex        <= '0;
                end else begin
                    rd_loaded     <= 1'b1;
                    rd_idx        <= rd_idx + IDX_W'(1);
                    xIndex        <= ADDR_W'(rd_idx);
                    yIndex        <= ADDR_W'(rd_idx);
                    xValid        <= (int'(rd_idx) < X_BINS);
                    yValid        <= (int'(rd_idx) < Y_BINS);
                    xHistogramOut <= x_rd;
                    yHistogramOut <= y_rd;
                end
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_projection_histogram_engine.sv
`default_nettype none
// Bench for projection_histogram_engine: table-driven peak vectors, randomised
// frames against an array-based bin model, and scoreboarded readouts.
module tb_projection_histogram_engine;
    localparam int XB   = 240;
    localparam int YB   = 180;
    localparam int AW   = 8;
    localparam int CW   = 8;
    localparam int CMAX = 255;
    localparam int MAXB = 240;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [AW-1:0] xAddress = '0, yAddress = '0;
    logic          pixelData = 1'b0, pixelValid = 1'b0;
    logic          startHistogram = 1'b0, frameAccum = 1'b0, stopHistogram = 1'b0;
    logic          clearHistogram = 1'b0, readHistogram = 1'b0, outReady = 1'b0;
    logic [CW-1:0] xHistogramOut, yHistogramOut, xPeakCount, yPeakCount;
    logic [AW-1:0] xIndex, yIndex, xPeakBin, yPeakBin;
    logic          xValid, yValid, histogramClear, readDone, busy;

    projection_histogram_engine #(
        .X_BINS(XB), .Y_BINS(YB), .ADDR_W(AW), .COUNT_W(CW)
    ) dut (
        .clk(clk), .reset(reset),
        .xAddress(xAddress), .yAddress(yAddress),
        .pixelData(pixelData), .pixelValid(pixelValid),
        .startHistogram(startHistogram), .frameAccum(frameAccum),
        .stopHistogram(stopHistogram), .clearHistogram(clearHistogram),
        .readHistogram(readHistogram), .outReady(outReady),
        .xHistogramOut(xHistogramOut), .yHistogramOut(yHistogramOut),
        .xIndex(xIndex), .yIndex(yIndex), .xValid(xValid), .yValid(yValid),
        .xPeakBin(xPeakBin), .yPeakBin(yPeakBin),
        .xPeakCount(xPeakCount), .yPeakCount(yPeakCount),
        .histogramClear(histogramClear), .readDone(readDone), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int mx [XB];
    int my [YB];
    int mxpb, mxpc, mypb, mypc;

    typedef struct {
        int x, y, d, v;
        int xpb, xpc, ypb, ypc;
    } vec_t;
    vec_t vecs [10];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        for (int i = 0; i < XB; i++) mx[i] = 0;
        for (int i = 0; i < YB; i++) my[i] = 0;
        mxpb = 0; mxpc = 0; mypb = 0; mypc = 0;
    endtask

    task automatic model_pixel(input int x, input int y, input int d, input int v);
        if (v != 0 && d != 0) begin
            if (x < XB) begin
                mx[x] = (mx[x] >= CMAX) ? CMAX : mx[x] + 1;
                if (mx[x] > mxpc) begin mxpb = x; mxpc = mx[x]; end
            end
            if (y < YB) begin
                my[y] = (my[y] >= CMAX) ? CMAX : my[y] + 1;
                if (my[y] > mypc) begin mypb = y; mypc = my[y]; end
            end
        end
    endtask

    task automatic drive_pixel(input int x, input int y, input int d, input int v);
        xAddress   = AW'(x);
        yAddress   = AW'(y);
        pixelData  = (d != 0);
        pixelValid = (v != 0);
        tick();
        model_pixel(x, y, d, v);
        pixelValid = 1'b0;
    endtask

    task automatic check_peaks(input string tag);
        check({tag, "_xPeakBin"},   xPeakBin,   mxpb);
        check({tag, "_xPeakCount"}, xPeakCount, mxpc);
        check({tag, "_yPeakBin"},   yPeakBin,   mypb);
        check({tag, "_yPeakCount"}, yPeakCount, mypc);
    endtask

    task automatic wait_clear(output int k);
        k = 0;
        do begin
            tick();
            k++;
        end while (!histogramClear && k < 1000);
        check("clear_pulse_seen", histogramClear, 1);
    endtask

    task automatic start_frame(input bit accum);
        int k;
        frameAccum     = accum;
        startHistogram = 1'b1;
        tick();
        startHistogram = 1'b0;
        frameAccum     = 1'b0;
        if (!accum) begin
            model_clear();
            wait_clear(k);
            check("clear_latency", k, MAXB);
            check("busy_in_accum_after_clear", busy, 1);
        end else begin
            check("busy_in_accum", busy, 1);
            check("no_clear_on_accum", histogramClear, 0);
        end
    endtask

    task automatic stop_with_pixel(input int x, input int y);
        xAddress      = AW'(x);
        yAddress      = AW'(y);
        pixelData     = 1'b1;
        pixelValid    = 1'b1;
        stopHistogram = 1'b1;
        tick();
        model_pixel(x, y, 1, 1);
        stopHistogram = 1'b0;
        pixelValid    = 1'b0;
        check("busy_after_stop", busy, 0);
    endtask

    // mode 0: outReady toggles 1,0,1,0; mode 1: random outReady
    task automatic readout(input int mode);
        int xi, yi;
        bit done, rdy, xv, yv;
        readHistogram = 1'b1;
        tick();
        readHistogram = 1'b0;
        check("read_busy", busy, 1);
        check("read_no_word_yet", xValid, 0);
        tick();
        xi = 0; yi = 0; done = 1'b0;
        for (int cyc = 0; cyc < 3000 && !done; cyc++) begin
            if (readDone) begin
                done = 1'b1;
            end else begin
                check("x_valid", xValid, int'(xi < XB));
                check("y_valid", yValid, int'(yi < YB));
                if (xValid && xi < XB) begin
                    check("x_index", xIndex, xi);
                    check("x_count", xHistogramOut, mx[xi]);
                end
                if (yValid && yi < YB) begin
                    check("y_index", yIndex, yi);
                    check("y_count", yHistogramOut, my[yi]);
                end
                xv  = xValid;
                yv  = yValid;
                rdy = (mode == 0) ? (cyc % 2 == 0) : ($urandom_range(0, 3) != 0);
                outReady = rdy;
                tick();
                if (rdy) begin
                    if (xv) xi++;
                    if (yv) yi++;
                end
            end
        end
        outReady = 1'b0;
        check("read_done_seen", done, 1);
        check("x_words_delivered", xi, XB);
        check("y_words_delivered", yi, YB);
        check("busy_after_read", busy, 0);
        tick();
        check("read_done_one_cycle", readDone, 0);
        check("x_valid_after_read", xValid, 0);
    endtask

    initial begin
        int k;
        vecs[0] = '{5,   3,   1, 1, 5, 1, 3, 1};
        vecs[1] = '{7,   4,   1, 1, 5, 1, 3, 1};
        vecs[2] = '{7,   4,   1, 1, 7, 2, 4, 2};
        vecs[3] = '{5,   3,   0, 1, 7, 2, 4, 2};
        vecs[4] = '{5,   3,   1, 0, 7, 2, 4, 2};
        vecs[5] = '{250, 10,  1, 1, 7, 2, 4, 2};
        vecs[6] = '{5,   200, 1, 1, 7, 2, 4, 2};
        vecs[7] = '{5,   10,  1, 1, 5, 3, 4, 2};
        vecs[8] = '{239, 179, 1, 1, 5, 3, 4, 2};
        vecs[9] = '{240, 180, 1, 1, 5, 3, 4, 2};
        model_clear();

        repeat (3) tick();
        check("rst_busy", busy, 0);
        check("rst_xValid", xValid, 0);
        check("rst_yValid", yValid, 0);
        check("rst_xPeakCount", xPeakCount, 0);
        check("rst_yPeakBin", yPeakBin, 0);
        check("rst_histogramClear", histogramClear, 0);
        check("rst_readDone", readDone, 0);
        check("rst_xHistogramOut", xHistogramOut, 0);
        reset = 1'b1;
        tick();

        readHistogram = 1'b1;
        tick();
        readHistogram = 1'b0;
        tick();
        check("read_in_idle_busy", busy, 0);
        check("read_in_idle_valid", xValid, 0);

        // Table vectors: peaks, ties, qualifiers and out-of-range addresses
        start_frame(1'b0);
        for (int i = 0; i < 10; i++) begin
            drive_pixel(vecs[i].x, vecs[i].y, vecs[i].d, vecs[i].v);
            check($sformatf("vec%0d_xPeakBin", i),   xPeakBin,   vecs[i].xpb);
            check($sformatf("vec%0d_xPeakCount", i), xPeakCount, vecs[i].xpc);
            check($sformatf("vec%0d_yPeakBin", i),   yPeakBin,   vecs[i].ypb);
            check($sformatf("vec%0d_yPeakCount", i), yPeakCount, vecs[i].ypc);
        end

        // Random pixels in the same frame, then toggled readout
        for (int i = 0; i < 1500; i++)
            drive_pixel($urandom_range(0, 255), $urandom_range(0, 255),
                        int'($urandom_range(0, 3) != 0), int'($urandom_range(0, 7) != 0));
        stop_with_pixel($urandom_range(0, 239), $urandom_range(0, 179));
        check_peaks("rand");
        readout(0);

        // Single column over two accumulated frames saturates bin 37
        start_frame(1'b0);
        for (int f = 0; f < 2; f++) begin
            if (f == 1) start_frame(1'b1);
            for (int y = 0; y < 179; y++) begin
                if (f == 0 && y == 90) begin
                    clearHistogram = 1'b1;
                    startHistogram = 1'b1;
                end
                drive_pixel(37, y, 1, 1);
                clearHistogram = 1'b0;
                startHistogram = 1'b0;
            end
            stop_with_pixel(37, 179);
        end
        check("sat_xPeakBin", xPeakBin, 37);
        check("sat_xPeakCount", xPeakCount, 255);
        check_peaks("sat");
        readout(1);

        // Clear and start together in DONE: only the clear sweep runs
        clearHistogram = 1'b1;
        startHistogram = 1'b1;
        tick();
        clearHistogram = 1'b0;
        startHistogram = 1'b0;
        model_clear();
        wait_clear(k);
        check("clear_only_latency", k, MAXB);
        check("clear_only_idle", busy, 0);
        check_peaks("clear_only");
        tick();
        check("clear_pulse_one_cycle", histogramClear, 0);
        check("clear_only_still_idle", busy, 0);
        start_frame(1'b1);
        stop_with_pixel(255, 255);
        readout(1);

        // Reset in the middle of an accumulating frame
        start_frame(1'b0);
        for (int i = 0; i < 1000; i++)
            drive_pixel($urandom_range(0, 239), $urandom_range(0, 179), 1, 1);
        reset = 1'b0;
        #2;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_xPeakCount", xPeakCount, 0);
        check("mid_rst_yPeakCount", yPeakCount, 0);
        check("mid_rst_xValid", xValid, 0);
        tick();
        reset = 1'b1;
        model_clear();
        tick();
        check("post_rst_idle", busy, 0);
        start_frame(1'b1);
        for (int i = 0; i < 200; i++)
            drive_pixel($urandom_range(0, 255), $urandom_range(0, 255), 1, 1);
        stop_with_pixel($urandom_range(0, 239), $urandom_range(0, 179));
        check_peaks("post_rst");
        readout(1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/projection_histogram_engine.md
# projection_histogram_engine

Parametrised successor to the median-filter front end's projection histogram unit. Accumulates per-column (x) and per-row (y) counts of set pixels over a streamed binary frame, with saturating counters, optional multi-frame accumulation, running peak tracking and a back-pressured readout stream. Sits between the binary-threshold stage and the ROI/centroid logic.

## Interface
- X_BINS, 240, number of column bins
- Y_BINS, 180, number of row bins
- ADDR_W, 8, width of xAddress/yAddress/index outputs; must satisfy 2^ADDR_W ≥ max(X_BINS, Y_BINS)
- COUNT_W, 8, bin counter width

- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset; one clock domain only
- xAddress  in  ADDR_W  column of current pixel
- yAddress  in  ADDR_W  row of current pixel
- pixelData  in  1  binary pixel value
- pixelValid  in  1  pixel qualifier
- startHistogram  in  1  pulse: begin frame
- frameAccum  in  1  sampled with startHistogram; 1 = keep existing counts
- stopHistogram  in  1  pulse: end frame
- clearHistogram  in  1  pulse: zero all bins
- readHistogram  in  1  pulse: begin readout
- outReady  in  1  downstream ready for readout
- xHistogramOut  out  COUNT_W  x bin count during readout
- yHistogramOut  out  COUNT_W  y bin count during readout
- xIndex, yIndex  out  ADDR_W  bin index of current output word
- xValid, yValid  out  1  readout word valid
- xPeakBin, yPeakBin  out  ADDR_W  index of largest bin
- xPeakCount, yPeakCount  out  COUNT_W  value of largest bin
- histogramClear  out  1  one-cycle pulse: clear sweep finished
- readDone  out  1  one-cycle pulse: readout finished
- busy  out  1  high in any state except IDLE/DONE

## Operation
- States: IDLE, CLEAR, ACCUM, DONE, READ. Reset → IDLE.
- IDLE/DONE + clearHistogram → CLEAR; sweep zeroes one x and one y bin per cycle for max(X_BINS,Y_BINS) cycles, also zeroes peaks, then pulses histogramClear and returns to IDLE.
- IDLE/DONE + startHistogram, frameAccum=0 → CLEAR, then ACCUM directly after the sweep (histogramClear still pulses). frameAccum=1 → ACCUM immediately, counts and peaks retained.
- ACCUM: each cycle with pixelValid=1 and pixelData=1, bin[xAddress] and bin[yAddress] increment by 1 in the same cycle. Bins are register arrays; back-to-back hits on the same bin every cycle count exactly, no hazard.
- Address ≥ X_BINS (resp. Y_BINS): that axis ignores the pixel; the other axis still counts.
- Counters saturate at 2^COUNT_W−1.
- Peak: on every increment, if new count > current peak count, peak bin/count update to that bin; ties keep the earlier peak. When x and y same-cycle, each axis independent.
- stopHistogram in ACCUM → DONE. Pixel on the same cycle as stop is counted.
- DONE + readHistogram → READ. Index starts at 0; xValid high while xIndex < X_BINS, yValid while yIndex < Y_BINS; both indices advance together on cycles where outReady=1. When both exhausted: readDone pulse, → DONE. Readout is non-destructive.
- Ignored: start/clear/read in ACCUM, CLEAR or READ; stop outside ACCUM; read in IDLE. Priority when simultaneous in IDLE/DONE: clear > start > read.

## Timing
- All outputs registered. Reset values: all outputs 0, all bins 0, peaks 0, state IDLE.
- Reset asserted mid-operation (any state): immediate return to reset values; no pulse emitted.
- Pixel sampled at edge N is visible in bins and peaks after edge N.
- Start (frameAccum=0) → ACCUM after 1 + max(X_BINS,Y_BINS) cycles; histogramClear asserts on the last sweep cycle's following edge, ACCUM entered same edge.
- readHistogram at edge N → first valid word (index 0) after edge N+1. Word held stable while outReady=0.
- Readout with outReady tied 1 takes max(X_BINS,Y_BINS) cycles; readDone pulses the cycle after the last valid word is accepted.

## Test plan
- Full frame 240×180, pixelData=1 always, frameAccum=0 → every x bin = 180, every y bin = 240 saturated to 255? No: y bins = 240, x bins = 180; xPeakBin=0, yPeakBin=0.
- Single column x=37 all set, COUNT_W=8, 2 frames with frameAccum=1 → x bin 37 = 255 (saturated from 360), xPeakBin=37, others 0.
- Pixels at xAddress=250 (out of range), yAddress=10 → y bin 10 increments, no x bin changes.
- Readout with outReady toggling 1,0,1,0 → each word held during 0 cycles, 240 x words and 180 y words delivered in order, readDone after x index 239 accepted.
- clearHistogram and startHistogram same cycle in DONE → only CLEAR runs, histogramClear after 240 cycles, state IDLE, all bins 0.
- reset low mid-ACCUM after 1000 pixels → all bins, peaks, valid flags 0, state IDLE; subsequent frame counts from zero.
